toom3_gf2_seqmul: RTL



---
 rtl/toom3_gf2_seqmul.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/toom3_gf2_seqmul.sv
// Sequential GF(2)[x] multiplier: Toom-3 over points 0, 1, x, x+1, inf with one shared limb multiplier.
// Optional macro TOOM3_GF2_MUL_PIPE_EN registers the limb multiplier output (latency 12 instead of 11).
module toom3_gf2_seqmul #(
  parameter int unsigned N = 64
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [3*N-1:0] a,
  input  logic [3*N-1:0] b,
  output logic           busy,
  output logic           done,
  output logic [6*N-2:0] w
);

  localparam int unsigned WA = 3 * N;
  localparam int unsigned WE = N + 2;
  localparam int unsigned WP = 2 * N + 3;
  localparam int unsigned WW = 6 * N - 1;

  typedef enum logic [3:0] {
    S_IDLE, S_EVAL, S_MUL0, S_MUL1, S_MUL2, S_MUL3, S_MUL4, S_MUL_DRAIN,
    S_INT_A, S_INT_D, S_INT_B, S_INT_C, S_PACK
  } state_t;

`ifdef TOOM3_GF2_MUL_PIPE_EN
  localparam state_t S_AFTER_MUL = S_MUL_DRAIN;
`else
  localparam state_t S_AFTER_MUL = S_INT_A;
`endif

  state_t          state;
  logic [WA-1:0]   a_q, b_q;
  logic [N-1:0]    pa1, pb1;
  logic [WE-1:0]   pax, pbx, pax1, pbx1;
  logic [WP-1:0]   w0, w1, wx, wx1, winf;
  logic [WP-1:0]   r_q, c3_q, s_q, t_q, c1_q, c2_q;
  logic [N-1:0]    a0, a1, a2, b0, b1, b2;
  logic [WE-1:0]   op_a, op_b;
  logic [WP-1:0]   prod_c, prod_in, c2_c;
  logic [2:0]      wr_idx;
  logic            wr_en;

  assign a0 = a_q[N-1:0];
  assign a1 = a_q[2*N-1:N];
  assign a2 = a_q[3*N-1:2*N];
  assign b0 = b_q[N-1:0];
  assign b1 = b_q[2*N-1:N];
  assign b2 = b_q[3*N-1:2*N];

  function automatic logic [WE-1:0] ev_x(input logic [N-1:0] l0, input logic [N-1:0] l1,
                                         input logic [N-1:0] l2);
    return WE'(l0) ^ (WE'(l1) << 1) ^ (WE'(l2) << 2);
  endfunction

  function automatic logic [WP-1:0] clmul(input logic [WE-1:0] x, input logic [WE-1:0] y);
    logic [WP-1:0] p;
    p = '0;
    for (int i = 0; i < int'(WE); i++) begin
      if (y[i]) p = p ^ (WP'(x) << i);
    end
    return p;
  endfunction

  // Exact division by (x+1): suffix XOR leaves the quotient shifted up by one.
  function automatic logic [WP-1:0] div_xp1(input logic [WP-1:0] r);
    logic [WP-1:0] q;
    q = '0;
    q[WP-1] = r[WP-1];
    for (int i = int'(WP) - 2; i >= 0; i--) begin
      q[i] = r[i] ^ q[i+1];
    end
    return q >> 1;
  endfunction

  always_comb begin
    op_a = '0;
    op_b = '0;
    case (state)
      S_MUL0:  begin op_a = WE'(a0); op_b = WE'(b0); end
      S_MUL1:  begin op_a = WE'(pa1); op_b = WE'(pb1); end
      S_MUL2:  begin op_a = pax; op_b = pbx; end
      S_MUL3:  begin op_a = pax1; op_b = pbx1; end
      S_MUL4:  begin op_a = WE'(a2); op_b = WE'(b2); end
      default: ;
    endcase
  end

  assign prod_c = clmul(op_a, op_b);
  assign c2_c   = div_xp1(t_q ^ s_q);

  // Select which point-product register captures the multiplier result this cycle.
`ifdef TOOM3_GF2_MUL_PIPE_EN
  logic [WP-1:0] mul_q;

  always_ff @(posedge clk) begin
    if (reset) mul_q <= '0;
    else       mul_q <= prod_c;
  end

  always_comb begin
    prod_in = mul_q;
    wr_en   = 1'b1;
    wr_idx  = 3'd0;
    case (state)
      S_MUL1:      wr_idx = 3'd0;
      S_MUL2:      wr_idx = 3'd1;
      S_MUL3:      wr_idx = 3'd2;
      S_MUL4:      wr_idx = 3'd3;
      S_MUL_DRAIN: wr_idx = 3'd4;
      default:     wr_en  = 1'b0;
    endcase
  end
`else
  always_comb begin
    prod_in = prod_c;
    wr_en   = 1'b1;
    wr_idx  = 3'd0;
    case (state)
      S_MUL0:  wr_idx = 3'd0;
      S_MUL1:  wr_idx = 3'd1;
      S_MUL2:  wr_idx = 3'd2;
      S_MUL3:  wr_idx = 3'd3;
      S_MUL4:  wr_idx = 3'd4;
      default: wr_en  = 1'b0;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      w     <= '0;
      a_q   <= '0;
      b_q   <= '0;
      pa1   <= '0;
      pb1   <= '0;
      pax   <= '0;
      pbx   <= '0;
      pax1  <= '0;
      pbx1  <= '0;
      w0    <= '0;
      w1    <= '0;
      wx    <= '0;
      wx1   <= '0;
      winf  <= '0;
      r_q   <= '0;
      c3_q  <= '0;
      s_q   <= '0;
      t_q   <= '0;
      c1_q  <= '0;
      c2_q  <= '0;
    end else begin
      done <= 1'b0;
      if (wr_en) begin
        case (wr_idx)
          3'd0:    w0   <= prod_in;
          3'd1:    w1   <= prod_in;
          3'd2:    wx   <= prod_in;
          3'd3:    wx1  <= prod_in;
          3'd4:    winf <= prod_in;
          default: ;
        endcase
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            busy  <= 1'b1;
            state <= S_EVAL;
          end
        end
        S_EVAL: begin
          pa1   <= a0 ^ a1 ^ a2;
          pb1   <= b0 ^ b1 ^ b2;
          pax   <= ev_x(a0, a1, a2);
          pbx   <= ev_x(b0, b1, b2);
          pax1  <= ev_x(a0, a1, a2) ^ WE'(a1) ^ WE'(a2);
          pbx1  <= ev_x(b0, b1, b2) ^ WE'(b1) ^ WE'(b2);
          state <= S_MUL0;
        end
        S_MUL0:      state <= S_MUL1;
        S_MUL1:      state <= S_MUL2;
        S_MUL2:      state <= S_MUL3;
        S_MUL3:      state <= S_MUL4;
        S_MUL4:      state <= S_AFTER_MUL;
        S_MUL_DRAIN: state <= S_INT_A;
        S_INT_A: begin
          r_q   <= w0 ^ w1 ^ wx ^ wx1;
          state <= S_INT_D;
        end
        S_INT_D: begin
          c3_q  <= div_xp1(r_q >> 1);
          state <= S_INT_B;
        end
        S_INT_B: begin
          s_q   <= w1 ^ w0 ^ c3_q ^ winf;
          t_q   <= (wx ^ w0 ^ (c3_q << 3) ^ (winf << 4)) >> 1;
          state <= S_INT_C;
        end
        S_INT_C: begin
          c2_q  <= c2_c;
          c1_q  <= s_q ^ c2_c;
          state <= S_PACK;
        end
        S_PACK: begin
          // Coefficient regions overlap by N-1 bits, so they are XORed together.
          w     <= WW'(w0) ^ (WW'(c1_q) << N) ^ (WW'(c2_q) << (2 * N))
                 ^ (WW'(c3_q) << (3 * N)) ^ (WW'(winf) << (4 * N));
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
